// File: rtl/pwm_breath_ctrl_if.sv
// Bundles the control and status signals of the breathing PWM LED driver.
// Latency: none (wiring only).
// Backpressure: none; all signals are level/pulse, with no handshake.
// Ports: enable, breath_en, static_duty (driven by the master);
//        led, period_start, breath_level (driven by the slave).
interface pwm_breath_ctrl_if #(
    parameter int CHANNELS = 3,
    parameter int PWM_BITS = 10
);
    logic                               enable;
    logic [CHANNELS-1:0]                breath_en;
    logic [CHANNELS*(PWM_BITS+1)-1:0]   static_duty;
    logic [CHANNELS-1:0]                led;
    logic                               period_start;
    logic [PWM_BITS:0]                  breath_level;

    modport master (
        output enable, breath_en, static_duty,
        input  led, period_start, breath_level
    );

    modport slave (
        input  enable, breath_en, static_duty,
        output led, period_start, breath_level
    );
endinterface

// File: rtl/pwm_breath_ctrl.sv
// Multi-channel PWM LED driver: per-channel static duty or a shared breathing envelope.
// Latency: led is registered 1 clk after pwm_cnt/shadow update; period_start pulses 1 clk at wrap.
// Backpressure: none; free-running. enable=0 blanks the LEDs and idles the engine on the next clk.
// Ports: clk, rst_n (async active-low); bus (slave): enable, breath_en, static_duty in;
//        led, period_start, breath_level out.
module pwm_breath_ctrl #(
    parameter int CHANNELS     = 3,
    parameter int PWM_BITS     = 10,
    parameter int PRESCALE     = 500,
    parameter int STEP_PERIODS = 256,
    parameter int MIN_LEVEL    = 32,
    parameter int HOLD_PERIODS = 0,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    pwm_breath_ctrl_if.slave bus
);

    localparam int FULL      = 2 ** PWM_BITS;
    localparam int LW        = PWM_BITS + 1;
    localparam int PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SW        = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam int HW        = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;
    localparam int HOLD_LAST = (HOLD_PERIODS > 0) ? HOLD_PERIODS - 1 : 0;

    localparam logic [PW-1:0]       PRESC_LAST  = PW'(PRESCALE - 1);
    localparam logic [SW-1:0]       STEP_LAST   = SW'(STEP_PERIODS - 1);
    localparam logic [HW-1:0]       HOLD_LAST_C = HW'(HOLD_LAST);
    localparam logic [LW:0]         FULL_X      = (LW + 1)'(FULL);
    localparam logic [LW-1:0]       FULL_L      = LW'(FULL);
    localparam logic [LW-1:0]       MIN_L       = LW'(MIN_LEVEL);
    localparam logic [LW-1:0]       QTR_L       = LW'(FULL / 4);
    localparam logic [CHANNELS-1:0] LED_OFF     = (ACTIVE_LOW != 0) ? '1 : '0;

    if (MIN_LEVEL >= 2 ** PWM_BITS) begin : g_chk_min
        $error("pwm_breath_ctrl: MIN_LEVEL must be below 2**PWM_BITS");
    end
    if (PRESCALE < 1) begin : g_chk_presc
        $error("pwm_breath_ctrl: PRESCALE must be at least 1");
    end
    if (STEP_PERIODS < 1) begin : g_chk_step
        $error("pwm_breath_ctrl: STEP_PERIODS must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        RISE,
        HOLD_TOP,
        FALL,
        HOLD_BOT
    } state_t;

    state_t                          state, state_nxt;
    logic [LW-1:0]                   level, level_nxt;
    logic [SW-1:0]                   step_cnt, step_nxt;
    logic [HW-1:0]                   hold_cnt, hold_nxt;

    logic [PW-1:0]                   presc_cnt;
    logic [PWM_BITS-1:0]             pwm_cnt;
    logic                            period_start_q;
    logic [CHANNELS-1:0]             led_q;
    logic [CHANNELS-1:0][LW-1:0]     shadow_duty;
    logic [CHANNELS-1:0][LW-1:0]     duty_sel;
    logic [CHANNELS-1:0]             pwm_on;

    logic                            tick;
    logic                            wrap;
    logic                            step_evt;
    logic                            hold_exit;
    logic [LW-1:0]                   rise_step;
    logic [LW-1:0]                   fall_step;
    logic [LW:0]                     rise_sum;
    logic [LW:0]                     fall_floor;

    assign tick     = (presc_cnt == PRESC_LAST);
    assign wrap     = tick && (pwm_cnt == '1);
    assign step_evt = wrap && (step_cnt == STEP_LAST);

    // With no hold configured, the bound is left on the next step event so the
    // envelope still dwells one step at each extreme.
    assign hold_exit = (HOLD_PERIODS == 0) ? step_evt
                                           : (wrap && (hold_cnt == HOLD_LAST_C));

    // Fine steps in the bottom quarter where the eye is most sensitive. The
    // falling side uses <= so the descent retraces the ascent (..4,8 / 8,4,3..).
    assign rise_step  = (level <  QTR_L) ? LW'(1) : LW'(4);
    assign fall_step  = (level <= QTR_L) ? LW'(1) : LW'(4);
    assign rise_sum   = {1'b0, level} + {1'b0, rise_step};
    assign fall_floor = {1'b0, MIN_L} + {1'b0, fall_step};

    // Breath envelope FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            level    <= MIN_L;
            step_cnt <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            level    <= level_nxt;
            step_cnt <= step_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    // Breath envelope FSM: next state and level.
    always_comb begin
        state_nxt = state;
        level_nxt = level;
        step_nxt  = step_cnt;
        hold_nxt  = hold_cnt;
        if (!bus.enable) begin
            state_nxt = IDLE;
            level_nxt = MIN_L;
            step_nxt  = '0;
            hold_nxt  = '0;
        end else begin
            if (wrap) begin
                step_nxt = step_evt ? '0 : step_cnt + 1'b1;
            end
            unique case (state)
                IDLE: begin
                    state_nxt = RISE;
                    level_nxt = MIN_L;
                    step_nxt  = '0;
                end
                RISE: begin
                    if (step_evt) begin
                        if (rise_sum >= FULL_X) begin
                            level_nxt = FULL_L;
                            state_nxt = HOLD_TOP;
                        end else begin
                            level_nxt = rise_sum[LW-1:0];
                        end
                    end
                end
                FALL: begin
                    if (step_evt) begin
                        // Compare against MIN+step rather than subtracting first,
                        // so the level can never underflow.
                        if ({1'b0, level} <= fall_floor) begin
                            level_nxt = MIN_L;
                            state_nxt = HOLD_BOT;
                        end else begin
                            level_nxt = level - fall_step;
                        end
                    end
                end
                HOLD_TOP, HOLD_BOT: begin
                    if (wrap) begin
                        hold_nxt = hold_cnt + 1'b1;
                    end
                    if (hold_exit) begin
                        hold_nxt  = '0;
                        step_nxt  = '0;
                        state_nxt = (state == HOLD_TOP) ? FALL : RISE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    level_nxt = MIN_L;
                end
            endcase
        end
    end

    // Per-channel duty source with saturation to full scale.
    always_comb begin
        logic [LW-1:0] raw;
        raw      = '0;
        duty_sel = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            raw         = bus.breath_en[i] ? level : bus.static_duty[i*LW +: LW];
            duty_sel[i] = (raw > FULL_L) ? FULL_L : raw;
        end
    end

    always_comb begin
        pwm_on = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_on[i] = ({1'b0, pwm_cnt} < shadow_duty[i]);
        end
    end

    // PWM timebase, shadow duty and registered LED outputs. The shadow is
    // loaded only at wrap; a breathing channel therefore picks up the level
    // that was current during the period just ended.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt      <= '0;
            pwm_cnt        <= '0;
            period_start_q <= 1'b0;
            shadow_duty    <= '0;
            led_q          <= LED_OFF;
        end else if (!bus.enable) begin
            presc_cnt      <= '0;
            pwm_cnt        <= '0;
            period_start_q <= 1'b0;
            shadow_duty    <= '0;
            led_q          <= LED_OFF;
        end else begin
            presc_cnt      <= tick ? '0 : presc_cnt + 1'b1;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
            period_start_q <= wrap;
            if (wrap) begin
                shadow_duty <= duty_sel;
            end
            led_q <= pwm_on ^ LED_OFF;
        end
    end

    assign bus.led          = led_q;
    assign bus.period_start = period_start_q;
    assign bus.breath_level = level;

endmodule

// File: tb/tb_pwm_breath_ctrl.sv
// Bench for pwm_breath_ctrl: two instances (fast/no-hold, prescaled/held) checked
// period by period against an envelope list and a duty/on-time model.
// Stimulus is directed start-up plus randomized duty and breath_en per period.
module tb_pwm_breath_ctrl;

    localparam int FULL = 16;
    localparam int MIN  = 1;

    logic        clk         = 1'b0;
    logic        rst_n       = 1'b1;
    logic        en_a        = 1'b0;
    logic        en_b        = 1'b0;
    logic [2:0]  breath_en   = '0;
    logic [14:0] static_duty = '0;
    logic        sel         = 1'b0;

    int n_vec = 0;
    int n_bad = 0;
    int env[$];
    int p;

    always #5 clk = ~clk;

    pwm_breath_ctrl_if #(.CHANNELS(3), .PWM_BITS(4)) if_a ();
    pwm_breath_ctrl_if #(.CHANNELS(3), .PWM_BITS(4)) if_b ();

    assign if_a.enable      = en_a;
    assign if_a.breath_en   = breath_en;
    assign if_a.static_duty = static_duty;
    assign if_b.enable      = en_b;
    assign if_b.breath_en   = breath_en;
    assign if_b.static_duty = static_duty;

    pwm_breath_ctrl #(
        .CHANNELS(3), .PWM_BITS(4), .PRESCALE(1), .STEP_PERIODS(1),
        .MIN_LEVEL(MIN), .HOLD_PERIODS(0), .ACTIVE_LOW(1)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a)
    );

    pwm_breath_ctrl #(
        .CHANNELS(3), .PWM_BITS(4), .PRESCALE(2), .STEP_PERIODS(1),
        .MIN_LEVEL(MIN), .HOLD_PERIODS(3), .ACTIVE_LOW(1)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b)
    );

    wire [2:0] led_s = sel ? if_b.led          : if_a.led;
    wire       ps_s  = sel ? if_b.period_start : if_a.period_start;
    wire [4:0] lvl_s = sel ? if_b.breath_level : if_a.breath_level;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Envelope as a list of per-period levels, index 0 = first period after enable.
    // Each bound is occupied for max(HOLD,1) extra periods; at the bottom the last
    // of those is the first list entry of the next ramp.
    task automatic build_env(input int hold);
        int l;
        int h;
        env.delete();
        l = MIN;
        h = (hold == 0) ? 1 : hold;
        env.push_back(l);
        while (l < FULL) begin
            l = l + ((l < FULL / 4) ? 1 : 4);
            if (l > FULL) l = FULL;
            env.push_back(l);
        end
        repeat (h) env.push_back(FULL);
        while (l > MIN) begin
            l = l - ((l <= FULL / 4) ? 1 : 4);
            if (l < MIN) l = MIN;
            env.push_back(l);
        end
        repeat (h - 1) env.push_back(MIN);
    endtask

    function automatic logic [2:0][4:0] exp_duty(input logic [2:0] be, input logic [14:0] sd,
                                                 input int lvl);
        logic [2:0][4:0] r;
        int v;
        r = '0;
        for (int c = 0; c < 3; c++) begin
            v    = be[c] ? lvl : int'(sd[c*5 +: 5]);
            r[c] = 5'((v > FULL) ? FULL : v);
        end
        return r;
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_led_a"},   32'(if_a.led),          32'h7);
        chk({tag, "_ps_a"},    32'(if_a.period_start), 32'h0);
        chk({tag, "_level_a"}, 32'(if_a.breath_level), MIN);
        chk({tag, "_led_b"},   32'(if_b.led),          32'h7);
        chk({tag, "_ps_b"},    32'(if_b.period_start), 32'h0);
        chk({tag, "_level_b"}, 32'(if_b.breath_level), MIN);
    endtask

    // Counts clocks from now until period_start is seen (bounded).
    task automatic wait_ps(input int budget, input int exp_clks, input string tag);
        int cnt;
        bit seen;
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < budget) begin
            @(negedge clk);
            cnt++;
            if (ps_s === 1'b1) seen = 1'b1;
        end
        chk(tag, seen ? 32'(cnt) : 32'hFFFF_FFFF, 32'(exp_clks));
    endtask

    // Entered on the negedge where period_start is high; returns on the next one.
    task automatic check_period(input int prs, input logic [2:0][4:0] ed, input int el,
                                input int chg_at, input logic [14:0] chg_val);
        logic [2:0][31:0] act;
        logic [2:0][31:0] expv;
        bit early_ps;
        chk("breath_level", 32'(lvl_s), 32'(el));
        act      = '0;
        expv     = '0;
        early_ps = 1'b0;
        for (int j = 0; j < 16 * prs; j++) begin
            @(negedge clk);
            if (j == chg_at) static_duty = chg_val;
            for (int c = 0; c < 3; c++) begin
                act[c][j]  = ~led_s[c];
                expv[c][j] = ((j / prs) < int'(ed[c]));
            end
            if (j < 16 * prs - 1 && ps_s !== 1'b0) early_ps = 1'b1;
        end
        chk("period_start_spacing", 32'(ps_s), 32'h1);
        chk("period_start_single", 32'(early_ps), 32'h0);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("led%0d_on_pattern", c), act[c], expv[c]);
        end
    endtask

    task automatic run_periods(input int prs, input int n, input bit rnd);
        logic [2:0][4:0] ed;
        for (int k = 0; k < n; k++) begin
            ed = exp_duty(breath_en, static_duty, env[(p - 1) % env.size()]);
            if (rnd) begin
                breath_en   = 3'($urandom_range(0, 7));
                static_duty = 15'($urandom);
            end
            check_period(prs, ed, env[p % env.size()], -1, '0);
            p++;
        end
    endtask

    initial begin
        logic [2:0][4:0] ed;

        // Asynchronous reset, away from any clock edge.
        #2 rst_n = 1'b0;
        #1 chk_reset("reset_initial");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Instance A: PRESCALE=1, no hold. Static duties 5 / 0 / 16.
        sel = 1'b0;
        build_env(0);
        breath_en   = 3'b000;
        static_duty = {5'd16, 5'd0, 5'd5};
        en_a        = 1'b1;
        wait_ps(100, 16, "first_period_start_a");
        p = 1;
        run_periods(1, 2, 1'b0);

        // Mid-period duty change: this period keeps 5, the next shows 10.
        ed = exp_duty(breath_en, static_duty, env[(p - 1) % env.size()]);
        check_period(1, ed, env[p % env.size()], 2, {5'd16, 5'd0, 5'd10});
        p++;
        run_periods(1, 1, 1'b0);

        // Random duty / breath selection over two envelope cycles.
        run_periods(1, 30, 1'b1);

        // Advance to a falling-ramp period, then drop enable mid-period.
        for (int k = 0; k < 20 && (p % env.size()) != 9; k++) begin
            run_periods(1, 1, 1'b1);
        end
        chk("level_before_drop", 32'(lvl_s), 32'(env[9]));
        repeat (5) @(negedge clk);
        en_a = 1'b0;
        @(negedge clk);
        chk("drop_led", 32'(led_s), 32'h7);
        chk("drop_period_start", 32'(ps_s), 32'h0);
        chk("drop_level", 32'(lvl_s), MIN);
        repeat (3) @(negedge clk);
        en_a = 1'b1;
        wait_ps(100, 16, "reenable_first_period_start");
        p = 1;
        run_periods(1, 4, 1'b1);
        en_a = 1'b0;

        // Instance B: PRESCALE=2, three-period hold at each bound.
        sel = 1'b1;
        build_env(3);
        breath_en   = 3'b101;
        static_duty = 15'($urandom);
        @(negedge clk);
        en_b = 1'b1;
        wait_ps(200, 32, "first_period_start_b");
        p = 1;
        run_periods(2, 24, 1'b1);

        // Reset asserted mid-period while B is running.
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset("reset_mid_period");
        en_b = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
